dsc_serial_mac: RTL

Parametrised deterministic stochastic-computing (DSC) multiply/multiply-accumulate engine; successor to the fixed two-mode serial multiplier.
- Converts NUM_INPUTS binary operands into unary bitstreams using the clock-division method.
- ANDs the streams and counts the ones, giving the exact product.
- Optionally accumulates products into a saturating register.
- Adds valid/ready handshakes on input and output, a zero-operand bypass, and a MAC mode. Sits between the operand fetch logic and the result writeback in the arch_sweep datapath.

---
 rtl/dsc_pkg.sv | 19 +
 rtl/dsc_unary_sng.sv | 30 +++
 rtl/dsc_serial_mac.sv | 137 +++++++++++++
 3 files changed

// File: rtl/dsc_pkg.sv
// Shared types and sizing helpers for the deterministic stochastic-computing MAC.
package dsc_pkg;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  typedef enum logic {
    MODE_MUL,
    MODE_MAC
  } mode_t;

  function automatic int unsigned prod_width(input int unsigned w, input int unsigned n);
    return w * n;
  endfunction

endpackage

// File: rtl/dsc_unary_sng.sv
// Clock-division unary stream generator: one W-bit counter compared against its operand.
module dsc_unary_sng #(
  parameter int unsigned W = 5
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         inc,
  input  logic [W-1:0] x,
  output logic         wrap,
  output logic         bit_s
);

  logic [W-1:0] cnt_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q <= '0;
    end else if (clr) begin
      cnt_q <= '0;
    end else if (inc) begin
      cnt_q <= cnt_q + W'(1);
    end
  end

  // Carry into the next stage fires only when this stage steps past all-ones.
  assign wrap  = inc & (cnt_q == '1);
  assign bit_s = (cnt_q < x);

endmodule

// File: rtl/dsc_serial_mac.sv
// Exact unary-stream multiplier with optional saturating accumulation and valid/ready handshakes.
module dsc_serial_mac
  import dsc_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 5,
  parameter int unsigned NUM_INPUTS = 2,
  parameter int unsigned PROD_WIDTH = prod_width(DATA_WIDTH, NUM_INPUTS),
  parameter int unsigned ACC_WIDTH  = NUM_INPUTS * DATA_WIDTH + 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_WIDTH-1:0] bin_data_in [NUM_INPUTS],
  input  logic                  mode,
  input  logic                  acc_clear,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [ACC_WIDTH-1:0]  bin_data_out,
  output logic                  sat,
  output logic                  busy
);

  state_t                  state_q, state_d;
  mode_t                   mode_q;
  logic [DATA_WIDTH-1:0]   ops_q [NUM_INPUTS];
  logic [PROD_WIDTH-1:0]   ones_q;
  logic [ACC_WIDTH-1:0]    acc_q;
  logic [ACC_WIDTH-1:0]    result_q;
  logic                    sat_q;

  logic                    accept;
  logic                    any_zero;
  logic [NUM_INPUTS:0]     carry;
  logic [NUM_INPUTS-1:0]   s_bits;
  logic                    last;
  logic [PROD_WIDTH-1:0]   prod_final;
  logic [ACC_WIDTH:0]      sum;
  logic                    ovf;
  logic [ACC_WIDTH-1:0]    acc_upd;
  logic [ACC_WIDTH-1:0]    acc_base;

  assign in_ready     = (state_q == IDLE);
  assign out_valid    = (state_q == DONE);
  assign busy         = (state_q != IDLE);
  assign bin_data_out = result_q;
  assign sat          = sat_q;
  assign accept       = in_valid & in_ready;

  always_comb begin
    any_zero = 1'b0;
    for (int unsigned i = 0; i < NUM_INPUTS; i++) begin
      if (bin_data_in[i] == '0) any_zero = 1'b1;
    end
  end

  // Stage i steps only when every lower stage wraps, forming one N*W-bit counter.
  assign carry[0] = (state_q == RUN);

  for (genvar g = 0; g < NUM_INPUTS; g++) begin : g_sng
    dsc_unary_sng #(.W(DATA_WIDTH)) u_sng (
      .clk   (clk),
      .rst   (rst),
      .clr   (accept),
      .inc   (carry[g]),
      .x     (ops_q[g]),
      .wrap  (carry[g+1]),
      .bit_s (s_bits[g])
    );
  end

  assign last       = carry[NUM_INPUTS];
  assign prod_final = ones_q + PROD_WIDTH'(&s_bits);
  assign sum        = {1'b0, acc_q} + (ACC_WIDTH + 1)'(prod_final);
  assign ovf        = sum[ACC_WIDTH];
  assign acc_upd    = ovf ? '1 : sum[ACC_WIDTH-1:0];
  assign acc_base   = acc_clear ? '0 : acc_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (in_valid) state_d = any_zero ? DONE : RUN;
      RUN:     if (last) state_d = DONE;
      DONE:    if (out_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      mode_q   <= MODE_MUL;
      ops_q    <= '{default: '0};
      ones_q   <= '0;
      acc_q    <= '0;
      result_q <= '0;
      sat_q    <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (acc_clear) begin
            acc_q <= '0;
            sat_q <= 1'b0;
          end
          if (accept) begin
            ops_q  <= bin_data_in;
            mode_q <= mode_t'(mode);
            ones_q <= '0;
            // Bypass: a zero operand makes the product 0, so MAC just republishes the accumulator.
            if (any_zero) result_q <= (mode_t'(mode) == MODE_MAC) ? acc_base : '0;
          end
        end
        RUN: begin
          if (&s_bits) ones_q <= ones_q + PROD_WIDTH'(1);
          if (last) begin
            if (mode_q == MODE_MAC) begin
              acc_q    <= acc_upd;
              sat_q    <= sat_q | ovf;
              result_q <= acc_upd;
            end else begin
              result_q <= ACC_WIDTH'(prod_final);
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule
